// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite read/write channel bundle between the load/store unit (master)
// and the memory fabric (slave).
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_awvalid;
  logic              m_awready;
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_wvalid;
  logic              m_wready;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_bvalid;
  logic              m_bready;
  logic [1:0]        m_bresp;

  modport master (
    output m_arvalid, m_araddr, m_rready,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arready, m_rvalid, m_rdata, m_rresp,
    input  m_awready, m_wready, m_bvalid, m_bresp
  );

  modport slave (
    input  m_arvalid, m_araddr, m_rready,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arready, m_rvalid, m_rdata, m_rresp,
    output m_awready, m_wready, m_bvalid, m_bresp
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit issuing one AXI4-Lite transaction per core request.
// Optional random issue delay for stall stress: define LSU_DELAY_INJECT_EN.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  lsu_axi_master_if.master  m_axi
);

  localparam int OFF_W = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
`ifdef LSU_DELAY_INJECT_EN
    , S_DELAY = 3'd6
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;

  logic              r_req_ready,  w_req_ready_nxt;
  logic              r_arvalid,    w_arvalid_nxt;
  logic [ADDR_W-1:0] r_araddr,     w_araddr_nxt;
  logic              r_rready,     w_rready_nxt;
  logic              r_awvalid,    w_awvalid_nxt;
  logic [ADDR_W-1:0] r_awaddr,     w_awaddr_nxt;
  logic              r_wvalid,     w_wvalid_nxt;
  logic [DATA_W-1:0] r_m_wdata,    w_m_wdata_nxt;
  logic [STRB_W-1:0] r_wstrb,      w_wstrb_nxt;
  logic              r_bready,     w_bready_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [DATA_W-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic              r_resp_err,   w_resp_err_nxt;

  logic              w_accept;
  logic              w_issue;
  logic              w_aw_pend;
  logic              w_w_pend;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [1:0]        w_cur_size;
  logic              w_cur_write;
  logic [DATA_W-1:0] w_cur_wdata;
  logic [OFF_W-1:0]  w_cur_off;
  logic              w_cur_mis;
  logic [ADDR_W-1:0] w_cur_aligned;
  logic [DATA_W-1:0] w_lane;

`ifdef LSU_DELAY_INJECT_EN
  logic [15:0]       r_lfsr;
  logic [4:0]        r_dcnt;
  logic [4:0]        w_dcnt_nxt;
`endif

  function automatic logic f_misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    logic m;
    case (s)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      2'd3:    m = (DATA_W != 64) || (|a[2:0]);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [STRB_W-1:0] f_strb(input logic [OFF_W-1:0] off, input logic [1:0] s);
    logic [7:0]  m;
    logic [15:0] t;
    case (s)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      2'd3:    m = 8'hFF;
      default: m = 8'h00;
    endcase
    t = {8'h00, m} << off;
    return t[STRB_W-1:0];
  endfunction

  // Keep the access-size bits, then fill the upper bits with zeros or the sign bit.
  function automatic logic [DATA_W-1:0] f_extend(input logic [DATA_W-1:0] lane,
                                                 input logic [1:0] s, input logic uns);
    logic [DATA_W-1:0] mask;
    logic              sgn;
    case (s)
      2'd0:    begin mask = DATA_W'(8'hFF);         sgn = lane[7];  end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      sgn = lane[15]; end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sgn = lane[31]; end
      default: begin mask = '1;                     sgn = 1'b0;     end
    endcase
    return (lane & mask) | ((sgn && !uns) ? ~mask : '0);
  endfunction

  assign w_accept      = req_valid && r_req_ready;
  assign w_cur_addr    = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_cur_size    = (r_state == S_IDLE) ? req_size  : r_size;
  assign w_cur_write   = (r_state == S_IDLE) ? req_write : r_write;
  assign w_cur_wdata   = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_cur_off     = w_cur_addr[OFF_W-1:0];
  assign w_cur_mis     = f_misaligned(w_cur_addr, w_cur_size);
  assign w_cur_aligned = {w_cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_lane        = m_axi.m_rdata >> {r_addr[OFF_W-1:0], 3'b000};

  // Request capture register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_addr     <= req_addr;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_write    <= req_write;
      r_wdata    <= req_wdata;
    end
  end

`ifdef LSU_DELAY_INJECT_EN
  // Free-running LFSR and issue-delay counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
      r_dcnt <= 5'd0;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_dcnt <= w_dcnt_nxt;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_arvalid_nxt    = r_arvalid;
    w_araddr_nxt     = r_araddr;
    w_rready_nxt     = r_rready;
    w_awvalid_nxt    = r_awvalid;
    w_awaddr_nxt     = r_awaddr;
    w_wvalid_nxt     = r_wvalid;
    w_m_wdata_nxt    = r_m_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_bready_nxt     = r_bready;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_issue          = 1'b0;
    w_aw_pend        = r_awvalid & ~m_axi.m_awready;
    w_w_pend         = r_wvalid & ~m_axi.m_wready;
`ifdef LSU_DELAY_INJECT_EN
    w_dcnt_nxt       = r_dcnt;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cur_mis) begin
            w_state_nxt      = S_DONE;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
`ifdef LSU_DELAY_INJECT_EN
            if (r_lfsr[4:0] == 5'd0) begin
              w_issue = 1'b1;
            end else begin
              w_state_nxt = S_DELAY;
              w_dcnt_nxt  = r_lfsr[4:0];
            end
`else
            w_issue = 1'b1;
`endif
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef LSU_DELAY_INJECT_EN
      S_DELAY: begin
        if (r_dcnt == 5'd1) begin
          w_issue = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt - 5'd1;
        end
      end
`endif
      S_AR: begin
        if (m_axi.m_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_R;
        end else begin
          w_state_nxt = S_AR;
        end
      end
      S_R: begin
        if (m_axi.m_rvalid) begin
          w_rready_nxt     = 1'b0;
          w_resp_rdata_nxt = f_extend(w_lane, r_size, r_unsigned);
          w_resp_err_nxt   = (m_axi.m_rresp != 2'b00);
          w_state_nxt      = S_DONE;
        end else begin
          w_state_nxt = S_R;
        end
      end
      S_AW_W: begin
        // Each channel retires on its own ready; move on once neither is pending.
        w_awvalid_nxt = w_aw_pend;
        w_wvalid_nxt  = w_w_pend;
        if (!w_aw_pend && !w_w_pend) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_B;
        end else begin
          w_state_nxt = S_AW_W;
        end
      end
      S_B: begin
        if (m_axi.m_bvalid) begin
          w_bready_nxt     = 1'b0;
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = (m_axi.m_bresp != 2'b00);
          w_state_nxt      = S_DONE;
        end else begin
          w_state_nxt = S_B;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_arvalid_nxt = 1'b0;
        w_rready_nxt  = 1'b0;
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        w_bready_nxt  = 1'b0;
      end
    endcase

    if (w_issue) begin
      if (w_cur_write) begin
        w_state_nxt   = S_AW_W;
        w_awvalid_nxt = 1'b1;
        w_wvalid_nxt  = 1'b1;
        w_awaddr_nxt  = w_cur_aligned;
        w_m_wdata_nxt = w_cur_wdata << {w_cur_off, 3'b000};
        w_wstrb_nxt   = f_strb(w_cur_off, w_cur_size);
      end else begin
        w_state_nxt   = S_AR;
        w_arvalid_nxt = 1'b1;
        w_araddr_nxt  = w_cur_aligned;
      end
    end else begin
      w_state_nxt = w_state_nxt;
    end

    w_resp_valid_nxt = (w_state_nxt == S_DONE);
    w_req_ready_nxt  = (w_state_nxt == S_IDLE);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_awaddr     <= '0;
      r_wvalid     <= 1'b0;
      r_m_wdata    <= '0;
      r_wstrb      <= '0;
      r_bready     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_araddr     <= w_araddr_nxt;
      r_rready     <= w_rready_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_bready     <= w_bready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  assign req_ready       = r_req_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_err        = r_resp_err;
  assign m_axi.m_arvalid = r_arvalid;
  assign m_axi.m_araddr  = r_araddr;
  assign m_axi.m_rready  = r_rready;
  assign m_axi.m_awvalid = r_awvalid;
  assign m_axi.m_awaddr  = r_awaddr;
  assign m_axi.m_wvalid  = r_wvalid;
  assign m_axi.m_wdata   = r_m_wdata;
  assign m_axi.m_wstrb   = r_wstrb;
  assign m_axi.m_bready  = r_bready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: a 32-bit instance for most cases and a
// 64-bit instance for dword and upper-lane loads.
module tb_lsu_axi_master;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid64, req_ready64, req_write64, req_unsigned64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic [1:0]  req_size64;
  logic        resp_valid64, resp_err64;
  logic [63:0] resp_rdata64;

  int n_cmp = 0;
  int n_mis = 0;
  int pulses = 0;
  int exp_pulses = 0;

  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
  lsu_axi_master_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .m_axi(bus32)
  );

  lsu_axi_master #(.ADDR_W(32), .DATA_W(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_write(req_write64),
    .req_addr(req_addr64), .req_size(req_size64), .req_unsigned(req_unsigned64),
    .req_wdata(req_wdata64), .resp_valid(resp_valid64), .resp_rdata(resp_rdata64),
    .resp_err(resp_err64), .m_axi(bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid) pulses = pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Aligned load on the 32-bit unit with arready/rvalid given immediately.
  task automatic load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] rdata, input logic [1:0] rresp,
                        input logic [31:0] exp_araddr, input logic [31:0] exp_rdata,
                        input logic exp_err);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_size = size;
    req_unsigned = uns; bus32.m_arready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_arvalid"}, bus32.m_arvalid, 1'b1);
    chk({tag, "_araddr"}, bus32.m_araddr, exp_araddr);
    @(negedge clk);
    bus32.m_arready = 1'b0;
    chk({tag, "_rready"}, bus32.m_rready, 1'b1);
    chk({tag, "_novalid"}, resp_valid, 1'b0);
    bus32.m_rvalid = 1'b1; bus32.m_rdata = rdata; bus32.m_rresp = rresp;
    @(negedge clk);
    bus32.m_rvalid = 1'b0; bus32.m_rresp = 2'b00;
    exp_pulses++;
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, resp_err, exp_err);
    @(negedge clk);
    chk({tag, "_idle"}, resp_valid, 1'b0);
    chk({tag, "_ready"}, req_ready, 1'b1);
  endtask

  task automatic load64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] rdata,
                        input logic [31:0] exp_araddr, input logic [63:0] exp_rdata);
    req_valid64 = 1'b1; req_write64 = 1'b0; req_addr64 = addr; req_size64 = size;
    req_unsigned64 = uns; bus64.m_arready = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk({tag, "_araddr"}, bus64.m_araddr, exp_araddr);
    @(negedge clk);
    bus64.m_arready = 1'b0;
    bus64.m_rvalid = 1'b1; bus64.m_rdata = rdata; bus64.m_rresp = 2'b00;
    @(negedge clk);
    bus64.m_rvalid = 1'b0;
    chk({tag, "_valid"}, resp_valid64, 1'b1);
    chk({tag, "_rdata"}, resp_rdata64, exp_rdata);
    chk({tag, "_err"}, resp_err64, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    req_valid64 = 1'b0; req_write64 = 1'b0; req_addr64 = 32'h0; req_size64 = 2'd0;
    req_unsigned64 = 1'b0; req_wdata64 = 64'h0;
    bus32.m_arready = 1'b0; bus32.m_rvalid = 1'b0; bus32.m_rdata = 32'h0; bus32.m_rresp = 2'b00;
    bus32.m_awready = 1'b0; bus32.m_wready = 1'b0; bus32.m_bvalid = 1'b0; bus32.m_bresp = 2'b00;
    bus64.m_arready = 1'b0; bus64.m_rvalid = 1'b0; bus64.m_rdata = 64'h0; bus64.m_rresp = 2'b00;
    bus64.m_awready = 1'b0; bus64.m_wready = 1'b0; bus64.m_bvalid = 1'b0; bus64.m_bresp = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", bus32.m_arvalid, 1'b0);
    chk("rst_awvalid", bus32.m_awvalid, 1'b0);
    chk("rst_wstrb", bus32.m_wstrb, 4'h0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    // Signed byte load from the top lane, with one cycle of arready stall
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0003; req_size = 2'd0;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("lb_arvalid", bus32.m_arvalid, 1'b1);
    chk("lb_araddr", bus32.m_araddr, 32'h8000_0000);
    chk("lb_busy", req_ready, 1'b0);
    @(negedge clk);
    chk("lb_arvalid_hold", bus32.m_arvalid, 1'b1);
    chk("lb_araddr_hold", bus32.m_araddr, 32'h8000_0000);
    bus32.m_arready = 1'b1;
    @(negedge clk);
    bus32.m_arready = 1'b0;
    chk("lb_ar_drop", bus32.m_arvalid, 1'b0);
    chk("lb_rready", bus32.m_rready, 1'b1);
    bus32.m_rvalid = 1'b1; bus32.m_rdata = 32'h80FF_FFFF; bus32.m_rresp = 2'b00;
    @(negedge clk);
    bus32.m_rvalid = 1'b0;
    exp_pulses++;
    chk("lb_valid", resp_valid, 1'b1);
    chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    chk("lb_err", resp_err, 1'b0);
    chk("lb_rready_drop", bus32.m_rready, 1'b0);
    @(negedge clk);
    chk("lb_pulse_end", resp_valid, 1'b0);
    chk("lb_rdata_hold", resp_rdata, 32'hFFFF_FF80);

    // Half store, awready two cycles before wready
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1002; req_size = 2'd1;
    req_wdata = 32'h0000_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sh_awvalid", bus32.m_awvalid, 1'b1);
    chk("sh_wvalid", bus32.m_wvalid, 1'b1);
    chk("sh_awaddr", bus32.m_awaddr, 32'h0000_1000);
    chk("sh_wdata", bus32.m_wdata, 32'hBEEF_0000);
    chk("sh_wstrb", bus32.m_wstrb, 4'b1100);
    bus32.m_awready = 1'b1;
    @(negedge clk);
    bus32.m_awready = 1'b0;
    chk("sh_aw_drop", bus32.m_awvalid, 1'b0);
    chk("sh_w_hold", bus32.m_wvalid, 1'b1);
    @(negedge clk);
    chk("sh_w_hold2", bus32.m_wvalid, 1'b1);
    chk("sh_wdata_hold", bus32.m_wdata, 32'hBEEF_0000);
    chk("sh_no_bready", bus32.m_bready, 1'b0);
    bus32.m_wready = 1'b1;
    @(negedge clk);
    bus32.m_wready = 1'b0;
    chk("sh_w_drop", bus32.m_wvalid, 1'b0);
    chk("sh_bready", bus32.m_bready, 1'b1);
    bus32.m_bvalid = 1'b1; bus32.m_bresp = 2'b00;
    @(negedge clk);
    bus32.m_bvalid = 1'b0;
    exp_pulses++;
    chk("sh_valid", resp_valid, 1'b1);
    chk("sh_err", resp_err, 1'b0);
    chk("sh_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    chk("sh_pulse_end", resp_valid, 1'b0);

    // Misaligned word load traps with no bus activity
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_1001; req_size = 2'd2;
    @(negedge clk);
    req_valid = 1'b0;
    exp_pulses++;
    chk("mis_valid", resp_valid, 1'b1);
    chk("mis_err", resp_err, 1'b1);
    chk("mis_arvalid", bus32.m_arvalid, 1'b0);
    @(negedge clk);
    chk("mis_arvalid2", bus32.m_arvalid, 1'b0);
    chk("mis_pulse_end", resp_valid, 1'b0);

    // Dword load on a 32-bit bus is illegal
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_size = 2'd3;
    req_unsigned = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_pulses++;
    chk("dw32_valid", resp_valid, 1'b1);
    chk("dw32_err", resp_err, 1'b1);
    chk("dw32_arvalid", bus32.m_arvalid, 1'b0);
    @(negedge clk);

    // Load variants: extension, lanes, bus error
    load32("lhu", 32'h0000_0002, 2'd1, 1'b1, 32'h8001_1234, 2'b00, 32'h0, 32'h0000_8001, 1'b0);
    load32("lh",  32'h0000_0000, 2'd1, 1'b0, 32'h0000_F00F, 2'b00, 32'h0, 32'hFFFF_F00F, 1'b0);
    load32("lbu", 32'h0000_0101, 2'd0, 1'b1, 32'h0000_A500, 2'b00, 32'h100, 32'h0000_00A5, 1'b0);
    load32("lw_slverr", 32'h0000_2000, 2'd2, 1'b0, 32'h1234_5678, 2'b10, 32'h2000, 32'h1234_5678, 1'b1);

    // Word store with both readies in the same cycle and a DECERR response
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_3000; req_size = 2'd2;
    req_wdata = 32'hCAFE_F00D;
    bus32.m_awready = 1'b1; bus32.m_wready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sw_wstrb", bus32.m_wstrb, 4'b1111);
    chk("sw_wdata", bus32.m_wdata, 32'hCAFE_F00D);
    @(negedge clk);
    bus32.m_awready = 1'b0; bus32.m_wready = 1'b0;
    chk("sw_aw_drop", bus32.m_awvalid, 1'b0);
    chk("sw_w_drop", bus32.m_wvalid, 1'b0);
    chk("sw_bready", bus32.m_bready, 1'b1);
    bus32.m_bvalid = 1'b1; bus32.m_bresp = 2'b11;
    @(negedge clk);
    bus32.m_bvalid = 1'b0; bus32.m_bresp = 2'b00;
    exp_pulses++;
    chk("sw_valid", resp_valid, 1'b1);
    chk("sw_err", resp_err, 1'b1);
    @(negedge clk);

    // 64-bit bus: full dword and sign-extended upper word
    load64("ld64", 32'h0000_0010, 2'd3, 1'b1, 64'hFEDC_BA98_7654_3210, 32'h10,
           64'hFEDC_BA98_7654_3210);
    load64("lw64_hi", 32'h0000_0014, 2'd2, 1'b0, 64'h8000_0000_0000_0000, 32'h10,
           64'hFFFF_FFFF_8000_0000);

    // Reset while waiting in R aborts without a completion
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000; req_size = 2'd2;
    bus32.m_arready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bus32.m_arready = 1'b0;
    chk("rr_in_r", bus32.m_rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_req_ready", req_ready, 1'b1);
    chk("rr_rready", bus32.m_rready, 1'b0);
    chk("rr_arvalid", bus32.m_arvalid, 1'b0);
    chk("rr_araddr", bus32.m_araddr, 32'h0);
    chk("rr_bready", bus32.m_bready, 1'b0);
    chk("rr_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    chk("rr_resp_valid2", resp_valid, 1'b0);
    @(negedge clk);
    chk("pulse_count", pulses, exp_pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
